multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//   Main control FSM for the multicycle RISC-V RV32I core. Sequences the shared datapath
//   (PC, IR, register file, single unified memory, the one ALU) across FETCH/DECODE/
//   EXECUTE/MEMORY/WRITEBACK cycles. Emits ALU_Op_o to ALU_Control, together with the
//   mux selects and write strobes, and stalls on a memory-ready handshake.
// PARAMETERS
//   MEM_WAIT_EN  1  1: memory states hold until mem_ready_i=1; 0: mem_ready_i ignored (always ready)
// PORTS
//   clk            in   1  core clock; all state changes on rising edge
//   reset          in   1  synchronous, active-high reset
//   opcode_i       in   7  IR[6:0] (valid from DECODE onward)
//   funct3_i       in   3  IR[14:12]; bit0 selects BEQ(0)/BNE(1)
//   zero_i         in   1  ALU zero flag
//   mem_ready_i    in   1  memory access completes this cycle
//   PC_Write_o     out  1  load PC
//   IR_Write_o     out  1  load IR (and old-PC register)
//   IorD_o         out  1  mem addr: 0=PC, 1=ALUOut
//   Mem_Read_o     out  1  memory read request
//   Mem_Write_o    out  1  memory write request
//   Reg_Write_o    out  1  register-file write
//   ALU_Src_A_o    out  2  00=PC 01=oldPC 10=rs1
//   ALU_Src_B_o    out  2  00=rs2 01=imm 10=const 4
//   ALU_Op_o       out  3  000=R-type 001=I-type 010=add 011=branch-sub (ALU_Control encoding)
//   Result_Src_o   out  2  00=ALUOut 01=MDR 10=ALU result (direct)
//   illegal_o      out  1  sticky: unsupported opcode decoded
//   state_o        out  4  current state code, for debug/verification
// BEHAVIOUR
//   - States (code): FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXR6 EXI7 ALUWB8
//     BRANCH9 JAL10 JALR11 LUI12 ERR15. Codes 13/14 unreachable; if entered, go to FETCH.
//   - reset=1 at an edge: state<=FETCH, illegal_o<=0. While reset=1, all strobes
//     (PC_Write, IR_Write, Mem_Read, Mem_Write, Reg_Write) forced 0 regardless of state.
//   - Outputs are Moore (decoded from state) except PC_Write in FETCH/BRANCH; unlisted
//     outputs are 0.
//   - FETCH: Mem_Read=1, IorD=0, SrcA=00, SrcB=10, ALU_Op=010, Result_Src=10.
//     IR_Write and PC_Write = mem_ready. Stay until mem_ready, then -> DECODE.
//   - DECODE: SrcA=01, SrcB=01, ALU_Op=010 (branch target -> ALUOut). Next by opcode:
//     0000011/0100011 -> MEMADR; 0110011 -> EXR; 0010011 -> EXI; 1100011 -> BRANCH;
//     1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; other -> ERR.
//   - MEMADR: SrcA=10, SrcB=01, ALU_Op=010; -> MEMRD if load, else MEMWR.
//   - MEMRD: Mem_Read=1, IorD=1; hold until mem_ready, then -> MEMWB.
//   - MEMWB: Reg_Write=1, Result_Src=01; -> FETCH.
//   - MEMWR: Mem_Write=1, IorD=1; hold until mem_ready, then -> FETCH. Mem_Write
//     stays asserted on every held cycle.
//   - EXR: SrcA=10, SrcB=00, ALU_Op=000. EXI: SrcA=10, SrcB=01, ALU_Op=001. Both -> ALUWB.
//   - ALUWB: Reg_Write=1, Result_Src=00; -> FETCH.
//   - BRANCH: SrcA=10, SrcB=00, ALU_Op=011, Result_Src=00;
//     PC_Write = zero_i XOR funct3_i[0]; -> FETCH.
//   - JAL: SrcA=01, SrcB=10, ALU_Op=010 (rd=oldPC+4); Result_Src=00, PC_Write=1
//     (PC<=ALUOut target); -> ALUWB.
//   - JALR: SrcA=10, SrcB=01, ALU_Op=010, Result_Src=10, PC_Write=1; -> EXJ path via
//     ALUWB with link value oldPC+4 muxed by datapath; -> ALUWB.
//   - LUI: SrcA=00 masked by datapath to 0, SrcB=01, ALU_Op=010; -> ALUWB.
//   - ERR: all strobes 0, illegal_o=1; remain until reset.
//   - Zero-wait latency (cycles per instr): R/I/JAL/JALR/LUI 4, load 5, store 4, branch 3.
//     Each memory stall cycle adds 1. With MEM_WAIT_EN=0, FETCH/MEMRD/MEMWR last 1 cycle.
//   - Reset asserted mid-instruction (e.g. in MEMWR with mem_ready=0): Mem_Write
//     drops to 0 in that same cycle; next state is FETCH; no partial write is committed.
// TESTING
//   - Reset then R-type (0110011), mem_ready=1 -> state 0,1,6,8,0; Reg_Write=1 only in
//     cycle 4; ALU_Op_o=000 in EXR.
//   - Load (0000011), mem_ready low for 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0;
//     Mem_Read=1 and IorD=1 all three MEMRD cycles; Reg_Write with Result_Src=01 in MEMWB.
//   - BEQ zero_i=1 -> PC_Write=1 in BRANCH; BNE (funct3=001) zero_i=1 -> PC_Write=0;
//     3 cycles each.
//   - Store with reset=1 during the second stalled MEMWR cycle -> Mem_Write=0 that cycle;
//     state_o=0 next cycle.
//   - Opcode 1111111 -> ERR (15); illegal_o=1; strobes 0 for 10 cycles; reset clears illegal_o.
//   - MEM_WAIT_EN=0, mem_ready_i=0 held -> load completes in 5 cycles; R-type in 4.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/
// writeback over the shared datapath and stalls memory states on mem_ready_i.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 when memory ready
// DECODE  | register read, branch target -> ALUOut
// MEMADR  | load/store address rs1+imm
// MEMRD   | data read at ALUOut
// MEMWB   | rd <= MDR
// MEMWR   | data write at ALUOut
// EXR     | R-type ALU op
// EXI     | I-type ALU op
// ALUWB   | rd <= ALUOut
// BRANCH  | compare rs1/rs2, conditional PC load
// JAL     | link oldPC+4, PC <= target
// JALR    | PC <= rs1+imm
// LUI     | 0+imm
// ERR     | unsupported opcode, parked until reset
module multicycle_main_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PC_Write_o,
  output logic       IR_Write_o,
  output logic       IorD_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       Reg_Write_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic [1:0] Result_Src_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_EXI    = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
    S_LUI    = 4'd12, S_ERR    = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t state, state_nxt;
  ctrl_t  ctrl_q;
  logic   mem_rdy;
  logic   unused_funct3;

  assign mem_rdy       = MEM_WAIT_EN ? mem_ready_i : 1'b1;
  assign unused_funct3 = ^funct3_i[2:1];

  // Moore part of the outputs; registered from the next state so they line up with state.
  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.src_b = 2'b10; c.alu_op = 3'b010; c.result_src = 2'b10; end
      S_DECODE: begin c.src_a = 2'b01; c.src_b = 2'b01; c.alu_op = 3'b010; end
      S_MEMADR: begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 3'b010; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.result_src = 2'b01; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXR:    begin c.src_a = 2'b10; c.alu_op = 3'b000; end
      S_EXI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 3'b001; end
      S_ALUWB:  begin c.reg_write = 1'b1; end
      S_BRANCH: begin c.src_a = 2'b10; c.alu_op = 3'b011; end
      S_JAL:    begin c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 3'b010; c.pc_write = 1'b1; end
      S_JALR:   begin
        c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 3'b010; c.result_src = 2'b10; c.pc_write = 1'b1;
      end
      S_LUI:    begin c.src_b = 2'b01; c.alu_op = 3'b010; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXR;
          OP_I:              state_nxt = S_EXI;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          default:           state_nxt = S_ERR;
        endcase
      end
      S_MEMADR: state_nxt = (opcode_i == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXR, S_EXI, S_JAL, S_JALR, S_LUI: state_nxt = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH:         state_nxt = S_FETCH;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH);
      illegal_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= decode_ctrl(state_nxt);
      if (state_nxt == S_ERR) illegal_o <= 1'b1;
    end
  end

  // Strobes are gated by reset combinationally so an aborted access never commits.
  assign PC_Write_o   = ~reset & (ctrl_q.pc_write
                                  | ((state == S_FETCH) & mem_rdy)
                                  | ((state == S_BRANCH) & (zero_i ^ funct3_i[0])));
  assign IR_Write_o   = ~reset & (state == S_FETCH) & mem_rdy;
  assign Mem_Read_o   = ~reset & ctrl_q.mem_read;
  assign Mem_Write_o  = ~reset & ctrl_q.mem_write;
  assign Reg_Write_o  = ~reset & ctrl_q.reg_write;
  assign IorD_o       = ctrl_q.iord;
  assign ALU_Src_A_o  = ctrl_q.src_a;
  assign ALU_Src_B_o  = ctrl_q.src_b;
  assign ALU_Op_o     = ctrl_q.alu_op;
  assign Result_Src_o = ctrl_q.result_src;
  assign state_o      = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: one instance with memory wait enabled and
// one with it disabled, both checked every cycle against an instruction-path reference model.
module tb_multicycle_main_control;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] op;
    logic [1:0] rs;
    logic       ill;
    logic [3:0] st;
  } obs_t;

  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode_i = 7'd0;
  logic [2:0] funct3_i = 3'd0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;

  logic       pcw0, irw0, iord0, mr0, mw0, rw0, ill0;
  logic [1:0] a0, b0, rs0;
  logic [2:0] op0;
  logic [3:0] st0;
  logic       pcw1, irw1, iord1, mr1, mw1, rw1, ill1;
  logic [1:0] a1, b1, rs1;
  logic [2:0] op1;
  logic [3:0] st1;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_WAIT_EN(1'b1)) dut_wait (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct3_i(funct3_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .PC_Write_o(pcw0), .IR_Write_o(irw0), .IorD_o(iord0),
    .Mem_Read_o(mr0), .Mem_Write_o(mw0), .Reg_Write_o(rw0), .ALU_Src_A_o(a0),
    .ALU_Src_B_o(b0), .ALU_Op_o(op0), .Result_Src_o(rs0), .illegal_o(ill0), .state_o(st0));

  multicycle_main_control #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct3_i(funct3_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .PC_Write_o(pcw1), .IR_Write_o(irw1), .IorD_o(iord1),
    .Mem_Read_o(mr1), .Mem_Write_o(mw1), .Reg_Write_o(rw1), .ALU_Src_A_o(a1),
    .ALU_Src_B_o(b1), .ALU_Op_o(op1), .Result_Src_o(rs1), .illegal_o(ill1), .state_o(st1));

  obs_t act0, act1;
  assign act0 = {pcw0, irw0, iord0, mr0, mw0, rw0, a0, b0, op0, rs0, ill0, st0};
  assign act1 = {pcw1, irw1, iord1, mr1, mw1, rw1, a1, b1, op1, rs1, ill1, st1};

  obs_t exp0[$];
  obs_t exp1[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_st[2];
  bit   m_ill[2];

  // Every instruction is a fixed walk of state codes; memory states may repeat while stalled.
  function automatic int path_next(int cur, logic [6:0] op);
    int p[5];
    p = '{0, 1, 15, -1, -1};
    case (op)
      LD:   p = '{0, 1, 2, 3, 4};
      ST:   p = '{0, 1, 2, 5, -1};
      RT:   p = '{0, 1, 6, 8, -1};
      IT:   p = '{0, 1, 7, 8, -1};
      BR:   p = '{0, 1, 9, -1, -1};
      JAL:  p = '{0, 1, 10, 8, -1};
      JALR: p = '{0, 1, 11, 8, -1};
      LUI:  p = '{0, 1, 12, 8, -1};
      default: p = '{0, 1, 15, -1, -1};
    endcase
    for (int i = 0; i < 5; i++)
      if (p[i] == cur) return (i < 4 && p[i+1] >= 0) ? p[i+1] : 0;
    return 0;
  endfunction

  function automatic int model_next(int cur, logic [6:0] op, bit rdy, bit r);
    if (r) return 0;
    if (cur == 15) return 15;
    if ((cur == 0 || cur == 3 || cur == 5) && !rdy) return cur;
    return path_next(cur, op);
  endfunction

  function automatic obs_t model_out(int cur, bit rdy, bit z, logic [2:0] f3, bit r, bit ill);
    obs_t o;
    o = '0;
    o.st  = 4'(cur);
    o.ill = ill;
    case (cur)
      0:  begin o.mr = 1; o.b = 2; o.op = 2; o.rs = 2; o.irw = rdy; o.pcw = rdy; end
      1:  begin o.a = 1; o.b = 1; o.op = 2; end
      2:  begin o.a = 2; o.b = 1; o.op = 2; end
      3:  begin o.mr = 1; o.iord = 1; end
      4:  begin o.rw = 1; o.rs = 1; end
      5:  begin o.mw = 1; o.iord = 1; end
      6:  begin o.a = 2; o.b = 0; o.op = 0; end
      7:  begin o.a = 2; o.b = 1; o.op = 1; end
      8:  begin o.rw = 1; o.rs = 0; end
      9:  begin o.a = 2; o.b = 0; o.op = 3; o.pcw = z ^ f3[0]; end
      10: begin o.a = 1; o.b = 2; o.op = 2; o.pcw = 1; end
      11: begin o.a = 2; o.b = 1; o.op = 2; o.rs = 2; o.pcw = 1; end
      12: begin o.b = 1; o.op = 2; end
      default: ;
    endcase
    if (r) begin o.pcw = 0; o.irw = 0; o.mr = 0; o.mw = 0; o.rw = 0; end
    return o;
  endfunction

  // Apply one cycle of inputs, queue the expected outputs of both instances, advance models.
  task automatic cycle(input bit r, input logic [6:0] op, input logic [2:0] f3,
                       input bit rdy, input bit z);
    int nxt;
    bit eff;
    reset = r; opcode_i = op; funct3_i = f3; mem_ready_i = rdy; zero_i = z;
    for (int k = 0; k < 2; k++) begin
      eff = (k == 1) ? 1'b1 : rdy;
      if (k == 0) exp0.push_back(model_out(m_st[k], eff, z, f3, r, m_ill[k]));
      else        exp1.push_back(model_out(m_st[k], eff, z, f3, r, m_ill[k]));
      nxt = model_next(m_st[k], op, eff, r);
      m_ill[k] = r ? 1'b0 : ((nxt == 15) ? 1'b1 : m_ill[k]);
      m_st[k] = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t e;
    cyc++;
    if (exp0.size() > 0) begin
      e = exp0.pop_front();
      total++;
      if (act0 !== e) begin
        bad++;
        $display("FAIL wait_inst cyc=%0d got=%h want=%h (state got=%0d want=%0d)",
                 cyc, act0, e, act0.st, e.st);
      end
    end
    if (exp1.size() > 0) begin
      e = exp1.pop_front();
      total++;
      if (act1 !== e) begin
        bad++;
        $display("FAIL nowait_inst cyc=%0d got=%h want=%h (state got=%0d want=%0d)",
                 cyc, act1, e, act1.st, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [6:0] ops[9];
    logic [6:0] cur_op;
    int sel;
    ops = '{LD, ST, RT, IT, BR, JAL, JALR, LUI, BAD};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_st = '{0, 0};
    m_ill = '{0, 0};

    // R-type, no stalls
    cycle(1, RT, 3'd0, 1, 0);
    repeat (4) cycle(0, RT, 3'd0, 1, 0);
    // load with two stalled MEMRD cycles
    cycle(1, LD, 3'd2, 1, 0);
    foreach (ops[i]) ;
    begin
      bit rdy_pat[8];
      rdy_pat = '{1, 1, 1, 0, 0, 1, 1, 1};
      for (int i = 0; i < 8; i++) cycle(0, LD, 3'd2, rdy_pat[i], 0);
    end
    // BEQ taken, BNE with zero set (not taken)
    cycle(1, BR, 3'd0, 1, 1);
    repeat (3) cycle(0, BR, 3'd0, 1, 1);
    cycle(1, BR, 3'd1, 1, 1);
    repeat (3) cycle(0, BR, 3'd1, 1, 1);
    // store aborted by reset in its second stalled MEMWR cycle
    cycle(1, ST, 3'd2, 1, 0);
    repeat (3) cycle(0, ST, 3'd2, 1, 0);
    cycle(0, ST, 3'd2, 0, 0);
    cycle(1, ST, 3'd2, 0, 0);
    cycle(0, ST, 3'd2, 1, 0);
    // illegal opcode parks in ERR until reset
    cycle(1, BAD, 3'd0, 1, 0);
    repeat (12) cycle(0, BAD, 3'd0, 1, 1);
    cycle(1, BAD, 3'd0, 1, 0);
    cycle(0, BAD, 3'd0, 1, 0);
    cycle(1, RT, 3'd0, 1, 0);

    // randomized run; opcode only changes while both instances sit in FETCH or ERR
    cur_op = RT;
    for (int n = 0; n < 1500; n++) begin
      if ((m_st[0] == 0 || m_st[0] == 15) && (m_st[1] == 0 || m_st[1] == 15)) begin
        sel = $urandom_range(0, 9);
        cur_op = (sel < 9) ? ops[sel] : 7'($urandom);
      end
      cycle($urandom_range(0, 49) == 0, cur_op, 3'($urandom), $urandom_range(0, 9) < 7,
            1'($urandom));
    end

    @(negedge clk);
    #1;
    total++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      bad++;
      $display("FAIL drain: pending got=%0d/%0d want=0/0", exp0.size(), exp1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
